// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit.
package lsu_pkg;

  // RV32I load/store funct3 values
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // RAM access size encoding
  localparam logic [1:0] HB_WORD = 2'b10;
  localparam logic [1:0] HB_HALF = 2'b01;
  localparam logic [1:0] HB_BYTE = 2'b00;

  // mcause codes reported on a faulting op
  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LD_ACCESS   = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ST_ACCESS   = 4'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  // Access-fault cause for a load or a store
  function automatic logic [3:0] access_cause(input logic we);
    return we ? CAUSE_ST_ACCESS : CAUSE_LD_ACCESS;
  endfunction

  // Misalign cause for a load or a store
  function automatic logic [3:0] misalign_cause(input logic we);
    return we ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
  endfunction

endpackage

// File: rtl/lsu_decode.sv
// Combinational decode of an incoming op: size, signedness and fault checks.
module lsu_decode #(
  parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
  parameter int unsigned RAM_BYTES = 16384
) (
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic        i_we,
  output logic [1:0]  o_hb,
  output logic        o_unsigned,
  output logic        o_illegal,
  output logic        o_misalign,
  output logic        o_out_of_range
);
  import lsu_pkg::*;

  logic [31:0] w_offset;

  // Size / signedness / legality from funct3; unsigned forms are loads only
  always_comb begin
    o_hb       = HB_WORD;
    o_unsigned = 1'b0;
    o_illegal  = 1'b0;
    case (i_funct3)
      F3_B:  o_hb = HB_BYTE;
      F3_H:  o_hb = HB_HALF;
      F3_W:  o_hb = HB_WORD;
      F3_BU: begin
        o_hb       = HB_BYTE;
        o_unsigned = 1'b1;
        o_illegal  = i_we;
      end
      F3_HU: begin
        o_hb       = HB_HALF;
        o_unsigned = 1'b1;
        o_illegal  = i_we;
      end
      default: o_illegal = 1'b1;
    endcase
  end

  // Offset wraps below the base, so one unsigned compare covers both ends
  assign w_offset       = i_addr - RAM_BASE;
  assign o_out_of_range = (w_offset >= 32'(RAM_BYTES));

  // Natural alignment for halfword and word accesses
  assign o_misalign = ((o_hb == HB_WORD) && (i_addr[1:0] != 2'b00)) ||
                      ((o_hb == HB_HALF) && i_addr[0]);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and the data RAM port.
module load_store_unit #(
  parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
  parameter int unsigned RAM_BYTES = 16384,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        op_valid_i,
  output logic        op_ready_o,
  input  logic        op_we_i,
  input  logic [2:0]  op_funct3_i,
  input  logic [31:0] op_addr_i,
  input  logic [31:0] op_wdata_i,
  input  logic [4:0]  op_rd_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic        res_wb_o,
  output logic [31:0] res_data_o,
  output logic [4:0]  res_rd_o,
  output logic        res_fault_o,
  output logic [3:0]  res_cause_o,
  output logic [31:0] res_badaddr_o,
  output logic        mem_req_o,
  output logic        mem_ce_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [1:0]  mem_hb_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);
  import lsu_pkg::*;

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  lsu_state_e r_state;
  lsu_state_e w_state_nxt;

  logic          r_we;
  logic [1:0]    r_hb;
  logic          r_unsigned;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [4:0]    r_rd;
  logic [31:0]   r_data;
  logic          r_fault;
  logic [3:0]    r_cause;
  logic [TW-1:0] r_tcnt;

  logic [1:0]    w_hb;
  logic          w_unsigned;
  logic          w_illegal;
  logic          w_misalign;
  logic          w_oor;
  logic          w_dec_fault;
  logic [3:0]    w_dec_cause;
  logic [TW-1:0] w_tcnt_inc;
  logic          w_timeout;
  logic [31:0]   w_rdata_ext;
  logic          w_resp;

  lsu_decode #(
    .RAM_BASE  (RAM_BASE),
    .RAM_BYTES (RAM_BYTES)
  ) u_decode (
    .i_funct3       (op_funct3_i),
    .i_addr         (op_addr_i),
    .i_we           (op_we_i),
    .o_hb           (w_hb),
    .o_unsigned     (w_unsigned),
    .o_illegal      (w_illegal),
    .o_misalign     (w_misalign),
    .o_out_of_range (w_oor)
  );

  // Fault priority: illegal funct3, then misalign, then range
  always_comb begin
    w_dec_fault = w_illegal | w_misalign | w_oor;
    if (!w_illegal && w_misalign) begin
      w_dec_cause = misalign_cause(op_we_i);
    end else begin
      w_dec_cause = access_cause(op_we_i);
    end
  end

  // Timeout fires on the REQ cycle whose missing grant would bring the count to TIMEOUT
  assign w_tcnt_inc = r_tcnt + TW'(1);
  assign w_timeout  = !mem_gnt_i && (w_tcnt_inc == TW'(TIMEOUT));

  // RAM always sign-extends; undo that for LBU/LHU
  always_comb begin
    w_rdata_ext = mem_rdata_i;
    if (r_unsigned) begin
      if (r_hb == HB_BYTE) begin
        w_rdata_ext = {24'b0, mem_rdata_i[7:0]};
      end else begin
        w_rdata_ext = {16'b0, mem_rdata_i[15:0]};
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (op_valid_i) begin
          w_state_nxt = w_dec_fault ? RESP : REQ;
        end
      end
      REQ: begin
        if (mem_gnt_i || w_timeout) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (res_ready_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Op latch, read-data capture and timeout counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_we       <= 1'b0;
      r_hb       <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_rd       <= 5'd0;
      r_data     <= 32'h0;
      r_fault    <= 1'b0;
      r_cause    <= 4'd0;
      r_tcnt     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (op_valid_i) begin
            r_we       <= op_we_i;
            r_hb       <= w_hb;
            r_unsigned <= w_unsigned;
            r_addr     <= op_addr_i;
            r_wdata    <= op_wdata_i;
            r_rd       <= op_rd_i;
            r_data     <= 32'h0;
            r_fault    <= w_dec_fault;
            r_cause    <= w_dec_cause;
            r_tcnt     <= '0;
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            if (!r_we) begin
              r_data <= w_rdata_ext;
            end
          end else begin
            r_tcnt <= w_tcnt_inc;
            if (w_timeout) begin
              r_fault <= 1'b1;
              r_cause <= access_cause(r_we);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign w_resp = (r_state == RESP);

  // Handshake and RAM port decode straight from registered state
  assign op_ready_o  = (r_state == IDLE);
  assign mem_req_o   = (r_state == REQ);
  assign mem_ce_o    = (r_state == REQ);
  assign mem_we_o    = r_we;
  assign mem_hb_o    = r_hb;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;

  // Result port, quiet outside RESP
  assign res_valid_o   = w_resp;
  assign res_wb_o      = w_resp && !r_fault && !r_we;
  assign res_data_o    = w_resp ? r_data : 32'h0;
  assign res_rd_o      = w_resp ? r_rd : 5'd0;
  assign res_fault_o   = w_resp && r_fault;
  assign res_cause_o   = (w_resp && r_fault) ? r_cause : 4'd0;
  assign res_badaddr_o = (w_resp && r_fault) ? r_addr : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: RAM model, directed cases and random ops vs a byte-array model.
module tb_load_store_unit;

  localparam int unsigned RAM_BYTES = 16384;
  localparam int unsigned TIMEOUT   = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        op_valid_i;
  logic        op_ready_o;
  logic        op_we_i;
  logic [2:0]  op_funct3_i;
  logic [31:0] op_addr_i;
  logic [31:0] op_wdata_i;
  logic [4:0]  op_rd_i;
  logic        res_valid_o;
  logic        res_ready_i;
  logic        res_wb_o;
  logic [31:0] res_data_o;
  logic [4:0]  res_rd_o;
  logic        res_fault_o;
  logic [3:0]  res_cause_o;
  logic [31:0] res_badaddr_o;
  logic        mem_req_o;
  logic        mem_ce_o;
  logic        mem_gnt_i;
  logic        mem_we_o;
  logic [1:0]  mem_hb_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  load_store_unit #(
    .RAM_BASE  (32'h0000_0000),
    .RAM_BYTES (RAM_BYTES),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .op_valid_i    (op_valid_i),
    .op_ready_o    (op_ready_o),
    .op_we_i       (op_we_i),
    .op_funct3_i   (op_funct3_i),
    .op_addr_i     (op_addr_i),
    .op_wdata_i    (op_wdata_i),
    .op_rd_i       (op_rd_i),
    .res_valid_o   (res_valid_o),
    .res_ready_i   (res_ready_i),
    .res_wb_o      (res_wb_o),
    .res_data_o    (res_data_o),
    .res_rd_o      (res_rd_o),
    .res_fault_o   (res_fault_o),
    .res_cause_o   (res_cause_o),
    .res_badaddr_o (res_badaddr_o),
    .mem_req_o     (mem_req_o),
    .mem_ce_o      (mem_ce_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_we_o      (mem_we_o),
    .mem_hb_o      (mem_hb_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_rdata_i   (mem_rdata_i)
  );

  // ---------------- RAM model ----------------
  logic [7:0]  ram [RAM_BYTES];
  logic [7:0]  mdl [RAM_BYTES];
  int          ram_lat   = 0;
  logic        ram_stall = 1'b0;
  int          ram_wait;
  logic [13:0] ra;

  function automatic logic [7:0] init_byte(input int i);
    logic [31:0] w;
    w = 32'hDEAD_BEEF;
    if (i >= 16 && i < 20) return w[8*(i-16) +: 8];
    return 8'((i * 37 + 11) ^ (i >> 6));
  endfunction

  task automatic mdl_init();
    for (int i = 0; i < RAM_BYTES; i++) mdl[i] = init_byte(i);
  endtask

  // Grant one cycle after req (plus ram_lat waits), toggling back to 0; store on the grant edge
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_gnt_i <= 1'b0;
      ram_wait  <= 0;
      for (int i = 0; i < RAM_BYTES; i++) ram[i] <= init_byte(i);
    end else begin
      mem_gnt_i <= 1'b0;
      if (mem_req_o && mem_gnt_i && mem_we_o) begin
        ram[mem_addr_o[13:0]] <= mem_wdata_o[7:0];
        if (mem_hb_o != 2'b00) ram[14'(mem_addr_o[13:0] + 14'd1)] <= mem_wdata_o[15:8];
        if (mem_hb_o == 2'b10) begin
          ram[14'(mem_addr_o[13:0] + 14'd2)] <= mem_wdata_o[23:16];
          ram[14'(mem_addr_o[13:0] + 14'd3)] <= mem_wdata_o[31:24];
        end
      end
      if (mem_req_o && !mem_gnt_i && !ram_stall) begin
        if (ram_wait >= ram_lat) begin
          mem_gnt_i <= 1'b1;
          ram_wait  <= 0;
        end else begin
          ram_wait <= ram_wait + 1;
        end
      end
    end
  end

  // Combinational lane-selected, sign-extended read
  always_comb begin
    ra = mem_addr_o[13:0];
    case (mem_hb_o)
      2'b10:   mem_rdata_i = {ram[14'(ra + 14'd3)], ram[14'(ra + 14'd2)],
                              ram[14'(ra + 14'd1)], ram[ra]};
      2'b01:   mem_rdata_i = {{16{ram[14'(ra + 14'd1)][7]}}, ram[14'(ra + 14'd1)], ram[ra]};
      default: mem_rdata_i = {{24{ram[ra][7]}}, ram[ra]};
    endcase
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: architectural outcome of one op, from the ISA rules on a byte array
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int lat, input logic stall,
                       output logic fault, output logic [3:0] cause, output logic [31:0] data,
                       output int reqs, output logic [1:0] hb);
    int   size;
    logic legal;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size  = 1 << f3[1:0];
    hb    = (size == 4) ? 2'b10 : (size == 2) ? 2'b01 : 2'b00;
    fault = 1'b0;
    cause = 4'd0;
    data  = 32'h0;
    reqs  = 0;
    if (!legal) begin
      fault = 1'b1; cause = we ? 4'd7 : 4'd5;
    end else if ((addr % size) != 0) begin
      fault = 1'b1; cause = we ? 4'd6 : 4'd4;
    end else if (addr >= RAM_BYTES) begin
      fault = 1'b1; cause = we ? 4'd7 : 4'd5;
    end else if (stall) begin
      fault = 1'b1; cause = we ? 4'd7 : 4'd5; reqs = TIMEOUT;
    end else begin
      reqs = lat + 2;
      for (int k = 0; k < size; k++) begin
        if (we) mdl[int'(addr) + k] = wdata[8*k +: 8];
        else    data = data | (32'(mdl[int'(addr) + k]) << (8 * k));
      end
      if (!we && !f3[2] && size < 4 && data[8*size-1]) data = data | (32'hFFFF_FFFF << (8 * size));
    end
  endtask

  // Issue one op, follow it to its result and retire it
  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd, input int lat,
                       input logic stall, input int hold,
                       output logic [31:0] got_data, output logic [3:0] got_cause);
    logic        e_fault;
    logic [3:0]  e_cause;
    logic [31:0] e_data;
    int          e_reqs;
    logic [1:0]  e_hb;
    int          cyc;
    int          reqs;
    int          n;
    logic        first;
    model(we, f3, addr, wdata, lat, stall, e_fault, e_cause, e_data, e_reqs, e_hb);
    ram_lat   = lat;
    ram_stall = stall;
    @(negedge clk_i);
    op_valid_i  = 1'b1;
    op_we_i     = we;
    op_funct3_i = f3;
    op_addr_i   = addr;
    op_wdata_i  = wdata;
    op_rd_i     = rd;
    n = 0;
    while (!op_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check("op_ready", 32'(op_ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    op_valid_i = 1'b0;
    cyc   = 0;
    reqs  = 0;
    first = 1'b1;
    do begin
      @(negedge clk_i);
      cyc++;
      if (mem_req_o) begin
        reqs++;
        if (first) begin
          first = 1'b0;
          check("mem_addr", mem_addr_o, addr);
          check("mem_hb", 32'(mem_hb_o), 32'(e_hb));
          check("mem_we", 32'(mem_we_o), 32'(we));
          check("mem_ce", 32'(mem_ce_o), 32'd1);
          if (we) check("mem_wdata", mem_wdata_o, wdata);
        end
      end
    end while (!res_valid_o && cyc < 3 * TIMEOUT);
    check("res_valid", 32'(res_valid_o), 32'd1);
    check("latency", 32'(cyc), 32'(e_reqs + 1));
    check("req_cycles", 32'(reqs), 32'(e_reqs));
    check("res_fault", 32'(res_fault_o), 32'(e_fault));
    check("res_wb", 32'(res_wb_o), 32'(!we && !e_fault));
    check("res_rd", 32'(res_rd_o), 32'(rd));
    if (e_fault) begin
      check("res_cause", 32'(res_cause_o), 32'(e_cause));
      check("res_badaddr", res_badaddr_o, addr);
      check("res_data_fault", res_data_o, 32'h0);
    end else if (!we) begin
      check("res_data", res_data_o, e_data);
    end
    got_data  = res_data_o;
    got_cause = res_cause_o;
    if (hold > 0) begin
      op_valid_i  = 1'b1;
      op_we_i     = 1'b0;
      op_funct3_i = 3'b010;
      op_addr_i   = 32'h0000_0040;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk_i);
        check("hold_valid", 32'(res_valid_o), 32'd1);
        check("hold_data", res_data_o, got_data);
        check("hold_cause", 32'(res_cause_o), 32'(got_cause));
        check("hold_op_ready", 32'(op_ready_o), 32'd0);
        check("hold_no_req", 32'(mem_req_o), 32'd0);
      end
      op_valid_i = 1'b0;
    end
    res_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    res_ready_i = 1'b0;
    @(negedge clk_i);
    check("res_valid_clear", 32'(res_valid_o), 32'd0);
    check("op_ready_idle", 32'(op_ready_o), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    logic [3:0]  c;
    logic [2:0]  ld_tbl [5];
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          sz;
    int          r;

    ld_tbl = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    rst_i       = 1'b0;
    op_valid_i  = 1'b0;
    op_we_i     = 1'b0;
    op_funct3_i = 3'd0;
    op_addr_i   = 32'h0;
    op_wdata_i  = 32'h0;
    op_rd_i     = 5'd0;
    res_ready_i = 1'b0;
    mdl_init();
    #1 rst_i = 1'b1;
    #1;
    check("rst_op_ready", 32'(op_ready_o), 32'd1);
    check("rst_res_valid", 32'(res_valid_o), 32'd0);
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_mem_ce", 32'(mem_ce_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'h0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    // Directed cases
    do_op(1'b0, 3'b010, 32'h10, 32'h0, 5'd5, 0, 1'b0, 0, d, c);
    check("lw_deadbeef", d, 32'hDEAD_BEEF);
    do_op(1'b1, 3'b000, 32'h13, 32'h0000_00A5, 5'd0, 0, 1'b0, 0, d, c);
    do_op(1'b0, 3'b100, 32'h13, 32'h0, 5'd6, 0, 1'b0, 0, d, c);
    check("lbu_a5", d, 32'h0000_00A5);
    do_op(1'b0, 3'b000, 32'h13, 32'h0, 5'd7, 1, 1'b0, 0, d, c);
    check("lb_a5", d, 32'hFFFF_FFA5);
    do_op(1'b0, 3'b010, 32'h10, 32'h0, 5'd8, 0, 1'b0, 0, d, c);
    check("lw_after_sb", d, 32'hA5AD_BEEF);
    do_op(1'b0, 3'b001, 32'h21, 32'h0, 5'd9, 0, 1'b0, 0, d, c);
    check("lh_misalign_cause", 32'(c), 32'd4);
    do_op(1'b1, 3'b010, 32'h22, 32'h1234_5678, 5'd0, 0, 1'b0, 0, d, c);
    check("sw_misalign_cause", 32'(c), 32'd6);
    do_op(1'b0, 3'b010, 32'h0001_0000, 32'h0, 5'd10, 0, 1'b0, 0, d, c);
    check("lw_range_cause", 32'(c), 32'd5);
    do_op(1'b1, 3'b010, 32'h40, 32'hCAFE_F00D, 5'd0, 0, 1'b1, 0, d, c);
    check("sw_timeout_cause", 32'(c), 32'd7);
    do_op(1'b1, 3'b100, 32'h40, 32'h0, 5'd0, 0, 1'b0, 0, d, c);
    check("sbu_illegal_cause", 32'(c), 32'd7);
    do_op(1'b0, 3'b011, 32'h21, 32'h0, 5'd3, 0, 1'b0, 0, d, c);
    check("illegal_over_misalign", 32'(c), 32'd5);
    do_op(1'b0, 3'b101, 32'h10, 32'h0, 5'd11, 2, 1'b0, 5, d, c);
    check("lhu_held", d, 32'h0000_BEEF);

    // Reset in the middle of a stalled request abandons the op
    ram_stall = 1'b1;
    @(negedge clk_i);
    op_valid_i  = 1'b1;
    op_we_i     = 1'b0;
    op_funct3_i = 3'b010;
    op_addr_i   = 32'h80;
    @(posedge clk_i);
    #1 op_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("pre_rst_req", 32'(mem_req_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check("rst_async_req", 32'(mem_req_o), 32'd0);
    check("rst_async_ready", 32'(op_ready_o), 32'd1);
    @(negedge clk_i);
    rst_i     = 1'b0;
    ram_stall = 1'b0;
    mdl_init();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("post_rst_no_valid", 32'(res_valid_o), 32'd0);
      check("post_rst_no_req", 32'(mem_req_o), 32'd0);
    end
    check("post_rst_ready", 32'(op_ready_o), 32'd1);

    // Random ops against the model
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 9));
      if (r < 8) f3 = we ? 3'($urandom_range(0, 2)) : ld_tbl[$urandom_range(0, 4)];
      else       f3 = 3'($urandom_range(0, 7));
      sz   = 1 << f3[1:0];
      addr = 32'($urandom_range(0, RAM_BYTES - 1));
      r    = int'($urandom_range(0, 9));
      if (r == 0)     addr = $urandom | 32'h0001_0000;
      else if (r < 8) addr = addr & ~32'(sz - 1);
      do_op(we, f3, addr, $urandom, 5'($urandom_range(0, 31)),
            int'($urandom_range(0, 2)), ($urandom_range(0, 15) == 0),
            int'($urandom_range(0, 2)), d, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
